// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite encodings and default-slave state type
package ahblite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_e;
endpackage

// File: rtl/ahblite_decode_mux_if.sv
// ahblite_decode_mux_if: master-side address phase, slave responses and error log of the decoder
interface ahblite_decode_mux_if #(parameter int NPORT = 13);
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [NPORT-1:0]    HSEL;
  logic [NPORT*32-1:0] S_HRDATA;
  logic [NPORT-1:0]    S_HREADYOUT;
  logic [NPORT-1:0]    S_HRESP;
  logic [31:0]         HRDATA;
  logic                HREADY;
  logic                HRESP;
  logic                ERR_CLR;
  logic [7:0]          ERR_CNT;
  logic [31:0]         ERR_ADDR;
  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP, ERR_CLR,
    output HSEL, HRDATA, HREADY, HRESP, ERR_CNT, ERR_ADDR
  );
  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP, ERR_CLR,
    input  HSEL, HRDATA, HREADY, HRESP, ERR_CNT, ERR_ADDR
  );
endinterface

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for unmapped transfers plus error log
module ahblite_default_slave import ahblite_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        hready,
    input  logic [1:0]  htrans,
    input  logic        hit,
    input  logic [31:0] haddr,
    input  logic        err_clr,
    output logic        ready,
    output logic        resp,
    output logic [7:0]  err_cnt,
    output logic [31:0] err_addr
);
    ds_state_e state, state_nxt;
    logic accept;
    assign accept = hready & htrans[1] & ~hit;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DS_IDLE;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) err_addr <= haddr;
            if (err_clr | accept) err_cnt <= err_clr ? {7'b0, accept} : err_cnt + {7'b0, err_cnt != 8'hFF};
        end
    end
    always_comb begin
        state_nxt = DS_IDLE;
        ready     = 1'b1;
        resp      = HRESP_OKAY;
        case (state)
            DS_IDLE: state_nxt = accept ? DS_ERR1 : DS_IDLE;
            DS_ERR1: begin
                state_nxt = DS_ERR2;
                ready     = 1'b0;
                resp      = HRESP_ERROR;
            end
            DS_ERR2: begin
                state_nxt = accept ? DS_ERR1 : DS_IDLE;
                resp      = HRESP_ERROR;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end
endmodule

// File: rtl/ahblite_decode_mux.sv
// ahblite_decode_mux: HADDR[31:16] base/mask decoder with registered data-phase response mux
module ahblite_decode_mux import ahblite_pkg::*; #(
    parameter int                  NPORT   = 13,
    parameter logic [NPORT-1:0]    PORT_EN = {NPORT{1'b1}},
    parameter logic [NPORT*16-1:0] BASE    = '0,
    parameter logic [NPORT*16-1:0] MASK    = '0
) (
    input logic HCLK,
    input logic HRESET,
    ahblite_decode_mux_if.slave bus
);
    localparam int IW = NPORT > 1 ? $clog2(NPORT) : 1;
    logic [NPORT-1:0] match;
    logic [31:0]      rdata [NPORT];
    logic [IW-1:0]    idx, sel_idx;
    logic             sel_vld, ds_ready, ds_resp;
    genvar i;
    for (i = 0; i < NPORT; i++) begin : g_dec
        assign match[i] = PORT_EN[i] & ((bus.HADDR[31:16] & MASK[16*i+:16]) == (BASE[16*i+:16] & MASK[16*i+:16]));
        assign rdata[i] = bus.S_HRDATA[32*i+:32];
    end
    // isolating the lowest set bit makes overlapping windows resolve to the lowest index
    assign bus.HSEL = match & (~match + NPORT'(1));
    always_comb begin
        idx = '0;
        for (int k = NPORT - 1; k >= 0; k--) if (match[k]) idx = IW'(k);
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_vld <= 1'b0;
            sel_idx <= '0;
        end else if (bus.HREADY) begin
            sel_vld <= |match;
            sel_idx <= idx;
        end
    end
    assign bus.HRDATA = sel_vld ? rdata[sel_idx] : 32'h0;
    assign bus.HREADY = sel_vld ? bus.S_HREADYOUT[sel_idx] : ds_ready;
    assign bus.HRESP  = sel_vld ? bus.S_HRESP[sel_idx] : ds_resp;
    ahblite_default_slave u_ds (
        .clk     (HCLK),
        .rst     (HRESET),
        .hready  (bus.HREADY),
        .htrans  (bus.HTRANS),
        .hit     (|match),
        .haddr   (bus.HADDR),
        .err_clr (bus.ERR_CLR),
        .ready   (ds_ready),
        .resp    (ds_resp),
        .err_cnt (bus.ERR_CNT),
        .err_addr(bus.ERR_ADDR)
    );
endmodule

// File: tb/tb_ahblite_decode_mux.sv
// tb_ahblite_decode_mux: directed scoreboard bench for the AHB-Lite decoder/response mux
module tb_ahblite_decode_mux;
    import ahblite_pkg::*;
    localparam int NP = 13;
    localparam logic [NP*16-1:0] BASE = {16'hF00C, 16'hF00B, 16'hF00A, 16'hF009, 16'hF008, 16'hF007,
                                         16'hF006, 16'hF005, 16'h2000, 16'h3000, 16'h4000, 16'h2000, 16'h0000};
    localparam logic [NP*16-1:0] MASK = {{8{16'hFFFF}}, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFF00, 16'hFFFF};
    logic clk = 1'b0;
    logic rst;
    int nchk = 0;
    int nerr = 0;
    typedef struct {string tag; logic [31:0] d; logic r; logic e;} exp_t;
    exp_t q[$];
    ahblite_decode_mux_if #(.NPORT(NP)) b ();
    ahblite_decode_mux_if #(.NPORT(NP)) b2 ();
    ahblite_decode_mux #(.NPORT(NP), .BASE(BASE), .MASK(MASK)) dut (
        .HCLK(clk), .HRESET(rst), .bus(b));
    ahblite_decode_mux #(.NPORT(NP), .PORT_EN(13'h1FFD), .BASE(BASE), .MASK(MASK)) dut2 (
        .HCLK(clk), .HRESET(rst), .bus(b2));
    assign b2.HADDR = b.HADDR;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected response is queued when the step is driven and retired at the next mid-cycle sample
    task automatic step(input string tag, input logic [31:0] d, input logic r, input logic e);
        exp_t x;
        q.push_back('{tag, d, r, e});
        @(negedge clk);
        x = q.pop_front();
        chk({x.tag, ".hrdata"}, b.HRDATA, x.d);
        chk({x.tag, ".hready"}, {31'b0, b.HREADY}, {31'b0, x.r});
        chk({x.tag, ".hresp"}, {31'b0, b.HRESP}, {31'b0, x.e});
    endtask

    initial begin
        rst = 1'b1;
        b.HADDR = '0; b.HTRANS = HTRANS_IDLE; b.S_HRDATA = '0; b.S_HREADYOUT = '1; b.S_HRESP = '0; b.ERR_CLR = 1'b0;
        b2.HTRANS = HTRANS_IDLE; b2.S_HRDATA = '0; b2.S_HREADYOUT = '1; b2.S_HRESP = '0; b2.ERR_CLR = 1'b0;
        repeat (2) tick();
        step("rst", 32'h0, 1'b1, 1'b0);
        chk("rst_cnt", {24'h0, b.ERR_CNT}, 32'h0);
        chk("rst_addr", b.ERR_ADDR, 32'h0);
        chk("rst_hsel", {19'h0, b.HSEL}, 32'h1);
        tick(); rst = 1'b0;
        b.HADDR = 32'h4000_0010; b.HTRANS = HTRANS_NONSEQ;
        b.S_HRDATA[64+:32] = 32'hA5A5_0001; b.S_HRDATA[96+:32] = 32'hC3C3_0003;
        @(negedge clk); chk("t1_hsel", {19'h0, b.HSEL}, 32'h4);
        tick(); b.HTRANS = HTRANS_IDLE; b.HADDR = '0;
        step("t1_data", 32'hA5A5_0001, 1'b1, 1'b0);
        tick(); b.HADDR = 32'h3000_0000; b.HTRANS = HTRANS_NONSEQ; b.S_HREADYOUT[3] = 1'b0;
        @(negedge clk); chk("t2_hsel", {19'h0, b.HSEL}, 32'h8);
        tick(); b.HADDR = '0;
        for (int k = 0; k < 3; k++) begin
            step("t2_wait", 32'hC3C3_0003, 1'b0, 1'b0);
            chk("t2_hsel0", {19'h0, b.HSEL}, 32'h1);
            tick();
        end
        b.S_HREADYOUT[3] = 1'b1; b.HTRANS = HTRANS_IDLE;
        step("t2_rel", 32'hC3C3_0003, 1'b1, 1'b0);
        tick(); b.HADDR = 32'h5000_0000; b.HTRANS = HTRANS_NONSEQ;
        @(negedge clk); chk("t3_hsel", {19'h0, b.HSEL}, 32'h0);
        tick(); b.HTRANS = HTRANS_IDLE;
        step("t3_err1", 32'h0, 1'b0, 1'b1);
        chk("t3_cnt", {24'h0, b.ERR_CNT}, 32'h1);
        chk("t3_addr", b.ERR_ADDR, 32'h5000_0000);
        tick(); step("t3_err2", 32'h0, 1'b1, 1'b1);
        tick(); step("t3_idle", 32'h0, 1'b1, 1'b0);
        tick(); step("t3_okay", 32'h0, 1'b1, 1'b0);
        chk("t3_cnt_hold", {24'h0, b.ERR_CNT}, 32'h1);
        b.HTRANS = HTRANS_NONSEQ;
        for (int k = 0; k < 253; k++) begin
            tick(); tick();
        end
        step("t4_pre", 32'h0, 1'b1, 1'b1);
        chk("t4_pre_cnt", {24'h0, b.ERR_CNT}, 32'hFE);
        b.HADDR = 32'h5A00_0000;
        for (int j = 0; j < 3; j++) begin
            tick(); step("t4_e1", 32'h0, 1'b0, 1'b1);
            chk("t4_sat", {24'h0, b.ERR_CNT}, 32'hFF);
            chk("t4_addr", b.ERR_ADDR, 32'h5A00_0000 + (j << 16));
            b.HADDR = 32'h5A00_0000 + ((j + 1) << 16);
            tick(); step("t4_e2", 32'h0, 1'b1, 1'b1);
        end
        b.ERR_CLR = 1'b1; b.HADDR = 32'h6000_0000;
        tick(); b.ERR_CLR = 1'b0; b.HTRANS = HTRANS_IDLE;
        step("t4_clr_e1", 32'h0, 1'b0, 1'b1);
        chk("t4_clr_err_cnt", {24'h0, b.ERR_CNT}, 32'h1);
        chk("t4_clr_err_addr", b.ERR_ADDR, 32'h6000_0000);
        tick(); b.ERR_CLR = 1'b1;
        step("t4_clr_e2", 32'h0, 1'b1, 1'b1);
        tick(); b.ERR_CLR = 1'b0;
        step("t4_clr_idle", 32'h0, 1'b1, 1'b0);
        chk("t4_clr_cnt", {24'h0, b.ERR_CNT}, 32'h0);
        chk("t4_clr_addr", b.ERR_ADDR, 32'h6000_0000);
        b.HADDR = 32'h2000_1234;
        #1;
        chk("t5_overlap", {19'h0, b.HSEL}, 32'h2);
        chk("t5_port_en", {19'h0, b2.HSEL}, 32'h10);
        b.HADDR = 32'h2100_0000;
        #1;
        chk("t5_wide", {19'h0, b.HSEL}, 32'h10);
        tick(); b.HADDR = 32'h5000_0000; b.HTRANS = HTRANS_NONSEQ;
        tick(); b.HTRANS = HTRANS_IDLE; rst = 1'b1;
        step("t6_err1", 32'h0, 1'b0, 1'b1);
        tick(); rst = 1'b0;
        step("t6_rst", 32'h0, 1'b1, 1'b0);
        chk("t6_cnt", {24'h0, b.ERR_CNT}, 32'h0);
        chk("t6_addr", b.ERR_ADDR, 32'h0);
        tick(); b.HADDR = 32'h3000_0000; b.HTRANS = HTRANS_NONSEQ; b.S_HREADYOUT[3] = 1'b0;
        tick(); b.HTRANS = HTRANS_IDLE; b.HADDR = 32'h5000_0000; rst = 1'b1;
        step("t7_wait", 32'hC3C3_0003, 1'b0, 1'b0);
        tick(); rst = 1'b0;
        step("t7_rst", 32'h0, 1'b1, 1'b0);
        b.S_HREADYOUT[3] = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
